jtdd_mcu_share: RTL and testbench
=================================

Name: jtdd_mcu_share

Overview:
Parametrised shared-RAM arbiter and interrupt bridge between the main CPU and the protection MCU.
- Owns a single-port synchronous shared RAM of 2^AW words of DW bits.
- MCU has fixed priority on the RAM port. CPU accesses are buffered and complete via a wait/ok handshake instead of being silently lost.
- Also carries the CPU→MCU NMI latch and the MCU→CPU IRQ line.
- Sits between the main CPU address decoder and the 63701 MCU core in the game top level.

Parameters:
AW, 9, shared RAM address width (depth 2^AW)
DW, 8, data width of the RAM and both buses
TMO, 64, CPU wait cycles before cpu_tmo is flagged (1..255)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous reset, active low
cpu_cs  in  1  CPU selects shared RAM
cpu_rd  in  1  CPU read strobe (qualified by cpu_cs)
cpu_we  in  1  CPU write strobe (qualified by cpu_cs)
cpu_addr  in  AW  CPU address
cpu_din  in  DW  CPU write data
cpu_dout  out  DW  CPU read data, held until next read completes
cpu_wait  out  1  CPU request outstanding
cpu_ok  out  1  one-cycle pulse, request completed
cpu_tmo  out  1  sticky: a CPU request waited ≥TMO cycles
mcu_cs  in  1  MCU accesses shared RAM this cycle
mcu_we  in  1  MCU write (qualified by mcu_cs)
mcu_addr  in  AW  MCU address
mcu_din  in  DW  MCU write data
mcu_dout  out  DW  RAM output; valid one cycle after an MCU read cycle
nmi_set  in  1  CPU request for MCU NMI, rising-edge sensitive
nmi_clr  in  1  MCU port bit, level high clears NMI
mcu_nmi  out  1  NMI to MCU
irq_req  in  1  MCU port bit requesting main CPU IRQ
main_irq  out  1  registered irq_req

Behaviour:
- Reset (rstn=0, async): FSM=IDLE; cpu_wait=0, cpu_ok=0, cpu_tmo=0; cpu_dout=0; mcu_nmi=0; main_irq=0; nmi_set edge register=0; wait counter=0. RAM contents are not cleared.
- RAM: read latency one clock. Write occurs on the clock edge of the granted cycle.
- Port grant each cycle:
  - mcu_cs=1 → MCU owns the port (address/data/we from the MCU side).
  - Otherwise the FSM may issue the CPU access.
  - mcu_dout reflects RAM q regardless of owner. The MCU only samples it after its own read.
- FSM states IDLE, WR_PEND, RD_REQ, RD_LAT:
  - IDLE:
    - cpu_cs&cpu_we: capture addr/data into the post buffer, go to WR_PEND. cpu_wait=1 from the next cycle.
    - Else cpu_cs&cpu_rd: capture addr, go to RD_REQ.
    - cpu_we and cpu_rd together: treat as a write.
  - WR_PEND: on the first cycle with mcu_cs=0, write the buffer into RAM, pulse cpu_ok, return to IDLE.
  - RD_REQ: on the first cycle with mcu_cs=0, present the address, go to RD_LAT.
  - RD_LAT: latch q into cpu_dout, pulse cpu_ok, return to IDLE. An mcu_cs in this cycle is still served; the latched q is from the CPU address.
- New CPU strobes are ignored while cpu_wait=1. The CPU must hold its request until cpu_ok.
- Minimum latency with mcu_cs=0: write → cpu_ok 2 cycles after the strobe; read → cpu_ok and data 3 cycles after the strobe.
- Wait counter:
  - Increments each cycle in WR_PEND/RD_REQ while mcu_cs=1; saturates at TMO.
  - Cleared on return to IDLE.
  - Reaching TMO sets cpu_tmo, which stays set until reset. The request continues waiting.
- NMI:
  - A rising edge of nmi_set (registered compare) sets mcu_nmi.
  - nmi_clr=1 forces mcu_nmi=0 and dominates; an edge arriving in the same cycle is dropped.
- main_irq = irq_req delayed one clock.

Optional Feature:
JTDD_MCU_SHARE_COLL_EN:
- Defined: adds output coll_cnt[15:0]. It increments (saturating at 16'hFFFF) each cycle the FSM is in WR_PEND or RD_REQ with mcu_cs=1. Reset value 0.
- Undefined: the port and counter do not exist; no other behaviour changes.

Test Plan:
- Reset: assert rstn=0 mid-read (RD_REQ) → all outputs 0, FSM IDLE next cycle after release, no cpu_ok pulse.
- CPU write/read, no MCU traffic: write 8'hA5 at 9'h1F0, then read 9'h1F0 → cpu_ok at +2 for the write; cpu_dout=8'hA5 with cpu_ok at +3 for the read.
- Collision: CPU write 8'h3C to 9'h010 while mcu_cs=1 for 5 cycles → cpu_wait=1 throughout, RAM unchanged until the first mcu_cs=0 cycle, cpu_ok one cycle later. MCU read of 9'h010 afterwards returns 8'h3C.
- Timeout: hold mcu_cs=1 for 70 cycles with a CPU read pending (TMO=64) → cpu_tmo rises at the 64th stalled cycle and stays 1 after the read completes.
- NMI: nmi_set 0→1 → mcu_nmi=1 next cycle. nmi_clr=1 → mcu_nmi=0. nmi_set held high → no re-set. Edge coincident with nmi_clr → mcu_nmi stays 0.
- IRQ and counter: irq_req pulse of 3 cycles → main_irq identical pulse delayed 1 cycle. With JTDD_MCU_SHARE_COLL_EN, the collision scenario above ends with coll_cnt=5.

Source files
------------

// File: rtl/jtdd_mcu_share.sv
// Shared-RAM arbiter and NMI/IRQ bridge between the main CPU and the protection MCU.
// Optional collision counter output coll_cnt is enabled by defining JTDD_MCU_SHARE_COLL_EN.
module jtdd_mcu_share #(
  parameter int AW  = 9,
  parameter int DW  = 8,
  parameter int TMO = 64
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cpu_cs,
  input  logic          cpu_rd,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_wait,
  output logic          cpu_ok,
  output logic          cpu_tmo,
  input  logic          mcu_cs,
  input  logic          mcu_we,
  input  logic [AW-1:0] mcu_addr,
  input  logic [DW-1:0] mcu_din,
  output logic [DW-1:0] mcu_dout,
  input  logic          nmi_set,
  input  logic          nmi_clr,
  output logic          mcu_nmi,
  input  logic          irq_req,
  output logic          main_irq
`ifdef JTDD_MCU_SHARE_COLL_EN
  ,
  output logic [15:0]   coll_cnt
`endif
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WR_PEND = 2'd1;
  localparam logic [1:0] ST_RD_REQ  = 2'd2;
  localparam logic [1:0] ST_RD_LAT  = 2'd3;

  localparam logic [7:0] TMO_MAX  = 8'(TMO);
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  logic [1:0]    r_state;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_cpu_dout;
  logic          r_cpu_ok;
  logic          r_cpu_tmo;
  logic [7:0]    r_wait_cnt;
  logic          r_nmi_set_d;
  logic          r_mcu_nmi;
  logic          r_main_irq;
  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_ram_q;

  logic          w_ram_we;
  logic [AW-1:0] w_ram_addr;
  logic [DW-1:0] w_ram_din;
  logic          w_stall;
  logic          w_nmi_edge;

  // A CPU request parked in WR_PEND/RD_REQ loses the port whenever the MCU is active.
  assign w_stall    = ((r_state == ST_WR_PEND) || (r_state == ST_RD_REQ)) && mcu_cs;
  assign w_nmi_edge = nmi_set && !r_nmi_set_d;

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_ram_we   = 1'b0;
    w_ram_addr = r_addr;
    w_ram_din  = r_wdata;
    if (mcu_cs) begin
      w_ram_we   = mcu_we;
      w_ram_addr = mcu_addr;
      w_ram_din  = mcu_din;
    end else if (r_state == ST_WR_PEND) begin
      w_ram_we = 1'b1;
    end
  end

  // NOTE: the RAM array has no reset branch; contents survive rstn and map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_ram_we) r_mem[w_ram_addr] <= w_ram_din;
    r_ram_q <= r_mem[w_ram_addr];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cpu_dout <= '0;
      r_cpu_ok   <= 1'b0;
    end else begin
      r_cpu_ok <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cpu_cs && cpu_we) begin
            r_addr  <= cpu_addr;
            r_wdata <= cpu_din;
            r_state <= ST_WR_PEND;
          end else if (cpu_cs && cpu_rd) begin
            r_addr  <= cpu_addr;
            r_state <= ST_RD_REQ;
          end
        end
        ST_WR_PEND: begin
          if (!mcu_cs) begin
            r_cpu_ok <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        ST_RD_REQ: begin
          if (!mcu_cs) r_state <= ST_RD_LAT;
        end
        ST_RD_LAT: begin
          // q here still holds the CPU address read, even if the MCU owns the port now.
          r_cpu_dout <= r_ram_q;
          r_cpu_ok   <= 1'b1;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wait_cnt <= '0;
      r_cpu_tmo  <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_wait_cnt <= '0;
      end else if (w_stall && (r_wait_cnt != TMO_MAX)) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
      if (w_stall && (r_wait_cnt == TMO_LAST)) r_cpu_tmo <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_nmi_set_d <= 1'b0;
      r_mcu_nmi   <= 1'b0;
      r_main_irq  <= 1'b0;
    end else begin
      r_nmi_set_d <= nmi_set;
      r_main_irq  <= irq_req;
      if (nmi_clr)         r_mcu_nmi <= 1'b0;
      else if (w_nmi_edge) r_mcu_nmi <= 1'b1;
    end
  end

`ifdef JTDD_MCU_SHARE_COLL_EN
  logic [15:0] r_coll_cnt;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_coll_cnt <= '0;
    end else if (w_stall && (r_coll_cnt != 16'hFFFF)) begin
      r_coll_cnt <= r_coll_cnt + 16'd1;
    end
  end
  assign coll_cnt = r_coll_cnt;
`endif

  assign cpu_dout = r_cpu_dout;
  assign cpu_wait = (r_state != ST_IDLE);
  assign cpu_ok   = r_cpu_ok;
  assign cpu_tmo  = r_cpu_tmo;
  assign mcu_dout = r_ram_q;
  assign mcu_nmi  = r_mcu_nmi;
  assign main_irq = r_main_irq;

endmodule

// File: tb/tb_jtdd_mcu_share.sv
// Self-checking bench for jtdd_mcu_share: scoreboard queues for CPU and MCU reads,
// latency, collision, timeout, reset, NMI and IRQ scenarios.
module tb_jtdd_mcu_share;

  localparam int AW  = 9;
  localparam int DW  = 8;
  localparam int TMO = 64;

  logic          clk;
  logic          rstn;
  logic          cpu_cs, cpu_rd, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic [DW-1:0] cpu_dout;
  logic          cpu_wait, cpu_ok, cpu_tmo;
  logic          mcu_cs, mcu_we;
  logic [AW-1:0] mcu_addr;
  logic [DW-1:0] mcu_din;
  logic [DW-1:0] mcu_dout;
  logic          nmi_set, nmi_clr, mcu_nmi;
  logic          irq_req, main_irq;
`ifdef JTDD_MCU_SHARE_COLL_EN
  logic [15:0]   coll_cnt;
`endif

  jtdd_mcu_share #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .cpu_cs   (cpu_cs),
    .cpu_rd   (cpu_rd),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .cpu_wait (cpu_wait),
    .cpu_ok   (cpu_ok),
    .cpu_tmo  (cpu_tmo),
    .mcu_cs   (mcu_cs),
    .mcu_we   (mcu_we),
    .mcu_addr (mcu_addr),
    .mcu_din  (mcu_din),
    .mcu_dout (mcu_dout),
    .nmi_set  (nmi_set),
    .nmi_clr  (nmi_clr),
    .mcu_nmi  (mcu_nmi),
    .irq_req  (irq_req),
    .main_irq (main_irq)
`ifdef JTDD_MCU_SHARE_COLL_EN
    ,
    .coll_cnt (coll_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] model [0:(1<<AW)-1];
  logic [DW-1:0] cpu_q [$];
  logic [DW-1:0] mcu_q [$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic mcu_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    mcu_cs = 1'b1; mcu_we = 1'b1; mcu_addr = addr; mcu_din = data;
    model[addr] = data;
    @(negedge clk);
    mcu_cs = 1'b0; mcu_we = 1'b0;
  endtask

  task automatic mcu_read(input logic [AW-1:0] addr);
    @(negedge clk);
    mcu_cs = 1'b1; mcu_we = 1'b0; mcu_addr = addr;
    mcu_q.push_back(model[addr]);
    @(negedge clk);
    mcu_cs = 1'b0;
    check("mcu_rd_data", 32'(mcu_dout), 32'(mcu_q.pop_front()));
  endtask

  // CPU access held until cpu_ok; the MCU occupies the port for 'stall' cycles after the strobe.
  task automatic cpu_access(input bit is_wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input int stall, input bit snoop);
    int ok_at;
    bit mcu_pend;
    logic [DW-1:0] old;
    @(negedge clk);
    cpu_cs = 1'b1; cpu_we = is_wr; cpu_rd = !is_wr; cpu_addr = addr; cpu_din = data;
    mcu_cs = 1'b0;
    old = model[addr];
    if (is_wr) model[addr] = data;
    else cpu_q.push_back(model[addr]);
    ok_at = -1;
    mcu_pend = 1'b0;
    for (int n = 1; n <= stall + 10 && ok_at < 0; n++) begin
      @(negedge clk);
      if (mcu_pend) begin
        check("mcu_snoop_old", 32'(mcu_dout), 32'(mcu_q.pop_front()));
        mcu_pend = 1'b0;
      end
      if (cpu_ok) begin
        ok_at = n;
        cpu_cs = 1'b0; cpu_we = 1'b0; cpu_rd = 1'b0;
        check("cpu_wait_clr", 32'(cpu_wait), 32'd0);
        if (!is_wr) check("cpu_rd_data", 32'(cpu_dout), 32'(cpu_q.pop_front()));
      end else begin
        check("cpu_wait", 32'(cpu_wait), 32'd1);
      end
      if (stall >= TMO && n == TMO)     check("tmo_before", 32'(cpu_tmo), 32'd0);
      if (stall >= TMO && n == TMO + 1) check("tmo_rise", 32'(cpu_tmo), 32'd1);
      mcu_cs = (ok_at < 0) && (n <= stall);
      mcu_we = 1'b0;
      mcu_addr = addr;
      if (mcu_cs && snoop) begin
        mcu_q.push_back(old);
        mcu_pend = 1'b1;
      end
    end
    mcu_cs = 1'b0;
    cpu_cs = 1'b0; cpu_we = 1'b0; cpu_rd = 1'b0;
    check(is_wr ? "wr_ok_latency" : "rd_ok_latency", 32'(ok_at), 32'(stall + (is_wr ? 2 : 3)));
    @(negedge clk);
    check("cpu_ok_pulse", 32'(cpu_ok), 32'd0);
  endtask

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  wr_t wr_tab [4] = '{'{9'h000, 8'h00}, '{9'h1FF, 8'hFF}, '{9'h0AA, 8'h55}, '{9'h155, 8'hC3}};

  initial begin
    logic [5:0] irq_pat;
    logic       irq_prev;
    rstn = 1'b0;
    cpu_cs = 0; cpu_rd = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
    mcu_cs = 0; mcu_we = 0; mcu_addr = '0; mcu_din = '0;
    nmi_set = 0; nmi_clr = 0; irq_req = 0;
    repeat (2) @(negedge clk);
    check("rst_cpu_wait", 32'(cpu_wait), 32'd0);
    check("rst_cpu_ok", 32'(cpu_ok), 32'd0);
    check("rst_cpu_tmo", 32'(cpu_tmo), 32'd0);
    check("rst_cpu_dout", 32'(cpu_dout), 32'd0);
    check("rst_mcu_nmi", 32'(mcu_nmi), 32'd0);
    check("rst_main_irq", 32'(main_irq), 32'd0);
    rstn = 1'b1;

    // Basic CPU write/read with no MCU traffic
    cpu_access(1'b1, 9'h1F0, 8'hA5, 0, 1'b0);
    cpu_access(1'b0, 9'h1F0, 8'h00, 0, 1'b0);
    foreach (wr_tab[i]) cpu_access(1'b1, wr_tab[i].addr, wr_tab[i].data, 0, 1'b0);
    foreach (wr_tab[i]) cpu_access(1'b0, wr_tab[i].addr, 8'h00, 0, 1'b0);
    foreach (wr_tab[i]) mcu_read(wr_tab[i].addr);

    // Collision: CPU write held off by 5 MCU cycles that read the old value
    mcu_write(9'h010, 8'h11);
    cpu_access(1'b1, 9'h010, 8'h3C, 5, 1'b1);
`ifdef JTDD_MCU_SHARE_COLL_EN
    check("coll_cnt", 32'(coll_cnt), 32'd5);
`endif
    mcu_read(9'h010);
    cpu_access(1'b0, 9'h010, 8'h00, 2, 1'b0);
    check("tmo_short_stall", 32'(cpu_tmo), 32'd0);

    // Timeout: read stalled 70 cycles
    cpu_access(1'b0, 9'h1F0, 8'h00, 70, 1'b0);
    check("tmo_sticky", 32'(cpu_tmo), 32'd1);

    // NMI edge / clear behaviour
    @(negedge clk); nmi_set = 1'b1;
    @(negedge clk); check("nmi_set_edge", 32'(mcu_nmi), 32'd1);
    @(negedge clk); nmi_clr = 1'b1;
    @(negedge clk); check("nmi_clr", 32'(mcu_nmi), 32'd0); nmi_clr = 1'b0;
    @(negedge clk); check("nmi_held_no_reset", 32'(mcu_nmi), 32'd0); nmi_set = 1'b0;
    @(negedge clk); nmi_set = 1'b1; nmi_clr = 1'b1;
    @(negedge clk); check("nmi_edge_vs_clr", 32'(mcu_nmi), 32'd0); nmi_clr = 1'b0;
    @(negedge clk); check("nmi_edge_dropped", 32'(mcu_nmi), 32'd0); nmi_set = 1'b0;

    // IRQ pulse delayed one clock
    irq_pat = 6'b001110;
    irq_prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) check("main_irq_delay", 32'(main_irq), 32'(irq_prev));
      irq_prev = irq_pat[i];
      irq_req = irq_pat[i];
    end
    @(negedge clk); check("main_irq_tail", 32'(main_irq), 32'(irq_prev));
    irq_req = 1'b0;

    // Reset mid-read while in RD_REQ, with NMI and IRQ active
    nmi_set = 1'b1;
    @(negedge clk); irq_req = 1'b1;
    check("nmi_pre_reset", 32'(mcu_nmi), 32'd1);
    cpu_cs = 1'b1; cpu_rd = 1'b1; cpu_addr = 9'h1F0;
    @(negedge clk); mcu_cs = 1'b1;
    @(negedge clk);
    check("pre_reset_wait", 32'(cpu_wait), 32'd1);
    rstn = 1'b0;
    #1;
    check("mid_rst_cpu_wait", 32'(cpu_wait), 32'd0);
    check("mid_rst_cpu_ok", 32'(cpu_ok), 32'd0);
    check("mid_rst_cpu_tmo", 32'(cpu_tmo), 32'd0);
    check("mid_rst_cpu_dout", 32'(cpu_dout), 32'd0);
    check("mid_rst_mcu_nmi", 32'(mcu_nmi), 32'd0);
    check("mid_rst_main_irq", 32'(main_irq), 32'd0);
    cpu_cs = 1'b0; cpu_rd = 1'b0; mcu_cs = 1'b0; irq_req = 1'b0; nmi_set = 1'b0;
    @(negedge clk); rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_ok", 32'(cpu_ok), 32'd0);
      check("post_rst_idle", 32'(cpu_wait), 32'd0);
    end
    cpu_access(1'b1, 9'h1F0, 8'h5A, 0, 1'b0);
    cpu_access(1'b0, 9'h010, 8'h00, 0, 1'b0);
    cpu_access(1'b0, 9'h1F0, 8'h00, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
